requant_unit: RTL and testbench

REQUANT_UNIT -- requirements
Module: requant_unit

---
 rtl/requant_unit.sv | 196 +++++++++++++++++++
 tb/tb_requant_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_unit.sv
`default_nettype none
// ============================================================================
// Module      : requant_unit
// Description : Per-channel requantizer. Fetches bias/scale for a channel,
//               then streams accumulators through a 3-stage pipeline
//               (add bias, scale, round/shift/relu/saturate) to a narrow
//               signed output stream with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module requant_unit #(
  parameter int ACC_WIDTH   = 32,
  parameter int BIAS_WIDTH  = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ch_start,
  input  logic [4:0]             layer_idx,
  input  logic [9:0]             ch_idx,
  input  logic                   relu_en,
  output logic                   param_rd,
  output logic [4:0]             param_layer_idx,
  output logic [9:0]             param_ch_idx,
  input  logic [BIAS_WIDTH-1:0]  bias_in,
  input  logic [SCALE_WIDTH-1:0] scale_in,
  input  logic                   param_valid,
  input  logic [ACC_WIDTH-1:0]   acc_in,
  input  logic                   acc_valid,
  input  logic                   acc_last,
  output logic                   acc_ready,
  output logic [OUT_WIDTH-1:0]   q_out,
  output logic                   q_valid,
  output logic                   q_last,
  input  logic                   q_ready,
  output logic                   busy,
  output logic                   done
);

  // Sum is one bit wider than the widest addend so it can never overflow;
  // the product carries the sum times a zero-extended (positive) scale.
  localparam int c_sum_w  = ((ACC_WIDTH > BIAS_WIDTH) ? ACC_WIDTH : BIAS_WIDTH) + 1;
  localparam int c_prod_w = c_sum_w + SCALE_WIDTH + 1;

  localparam logic signed [c_prod_w-1:0] c_one  = {{(c_prod_w-1){1'b0}}, 1'b1};
  localparam logic signed [c_prod_w-1:0] c_half = c_one << (SHIFT-1);
  localparam logic signed [c_prod_w-1:0] c_qmax = (c_one << (OUT_WIDTH-1)) - c_one;
  localparam logic signed [c_prod_w-1:0] c_qmin = ~c_qmax;

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_fetch = 3'd1;
  localparam logic [2:0] c_wait  = 3'd2;
  localparam logic [2:0] c_run   = 3'd3;
  localparam logic [2:0] c_drain = 3'd4;

  logic [2:0]                   r_state;
  logic [2:0]                   w_next_state;
  logic                         r_relu;
  logic [BIAS_WIDTH-1:0]        r_bias;
  logic [SCALE_WIDTH-1:0]       r_scale;

  logic                         w_adv;
  logic                         w_acc_fire;
  logic                         w_out_fire;

  logic signed [c_sum_w-1:0]    w_acc_ext;
  logic signed [c_sum_w-1:0]    w_bias_ext;
  logic signed [c_sum_w-1:0]    w_sum;
  logic signed [c_prod_w-1:0]   w_s1_ext;
  logic signed [c_prod_w-1:0]   w_scale_ext;
  logic signed [c_prod_w-1:0]   w_prod;
  logic signed [c_prod_w-1:0]   w_rnd;
  logic signed [c_prod_w-1:0]   w_shr;
  logic signed [c_prod_w-1:0]   w_clip;
  logic [OUT_WIDTH-1:0]         w_q;

  logic                         r_s1_v;
  logic                         r_s1_last;
  logic signed [c_sum_w-1:0]    r_s1;
  logic                         r_s2_v;
  logic                         r_s2_last;
  logic signed [c_prod_w-1:0]   r_p;

  // The whole pipeline moves only when the output register can be emptied.
  assign w_adv      = ~q_valid | q_ready;
  assign w_acc_fire = acc_valid & acc_ready;
  assign w_out_fire = q_valid & q_ready;

  assign w_acc_ext   = {{(c_sum_w-ACC_WIDTH){acc_in[ACC_WIDTH-1]}}, acc_in};
  assign w_bias_ext  = {{(c_sum_w-BIAS_WIDTH){r_bias[BIAS_WIDTH-1]}}, r_bias};
  assign w_sum       = w_acc_ext + w_bias_ext;
  assign w_s1_ext    = {{(c_prod_w-c_sum_w){r_s1[c_sum_w-1]}}, r_s1};
  assign w_scale_ext = {{(c_prod_w-SCALE_WIDTH){1'b0}}, r_scale};
  assign w_prod      = w_s1_ext * w_scale_ext;
  assign w_rnd       = r_p + c_half;
  assign w_shr       = w_rnd >>> SHIFT;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_next_state;
  end

  // FSM next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (ch_start) w_next_state = c_fetch;
      c_fetch: w_next_state = c_wait;
      c_wait:  if (param_valid) w_next_state = c_run;
      c_run:   if (w_acc_fire && acc_last) w_next_state = c_drain;
      c_drain: if (w_out_fire && q_last) w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  // FSM outputs: memory strobe, busy flag and input-side ready
  always_comb begin
    param_rd  = 1'b0;
    busy      = 1'b1;
    acc_ready = 1'b0;
    case (r_state)
      c_idle:  busy      = 1'b0;
      c_fetch: param_rd  = 1'b1;
      c_run:   acc_ready = w_adv;
      default: ;
    endcase
  end

  // Channel context captured with the start request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      param_layer_idx <= '0;
      param_ch_idx    <= '0;
      r_relu          <= 1'b0;
    end else if (r_state == c_idle && ch_start) begin
      param_layer_idx <= layer_idx;
      param_ch_idx    <= ch_idx;
      r_relu          <= relu_en;
    end
  end

  // Per-channel bias/scale captured from the parameter memory return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bias  <= '0;
      r_scale <= '0;
    end else if (r_state == c_wait && param_valid) begin
      r_bias  <= bias_in;
      r_scale <= scale_in;
    end
  end

  // Stage-3 combinational: optional relu, then clamp into the output range
  always_comb begin
    w_clip = w_shr;
    if (r_relu && w_shr[c_prod_w-1]) w_clip = '0;
    if (w_clip > c_qmax)      w_q = c_qmax[OUT_WIDTH-1:0];
    else if (w_clip < c_qmin) w_q = c_qmin[OUT_WIDTH-1:0];
    else                      w_q = w_clip[OUT_WIDTH-1:0];
  end

  // Three-stage datapath; every stage holds together when the output stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1      <= '0;
      r_s2_v    <= 1'b0;
      r_s2_last <= 1'b0;
      r_p       <= '0;
      q_valid   <= 1'b0;
      q_last    <= 1'b0;
      q_out     <= '0;
    end else if (w_adv) begin
      r_s1_v    <= w_acc_fire;
      r_s1_last <= w_acc_fire & acc_last;
      r_s1      <= w_sum;
      r_s2_v    <= r_s1_v;
      r_s2_last <= r_s1_v & r_s1_last;
      r_p       <= w_prod;
      q_valid   <= r_s2_v;
      q_last    <= r_s2_v & r_s2_last;
      if (r_s2_v) q_out <= w_q;
    end
  end

  // End-of-channel pulse, raised the cycle after the last beat leaves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (r_state == c_drain) & w_out_fire & q_last;
  end

endmodule
`default_nettype wire

// File: tb/tb_requant_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_requant_unit
// Description : Self-checking bench for requant_unit. Stimulus pushes the
//               expected output of each accepted beat into a scoreboard queue;
//               an independent monitor pops and compares on every output
//               transfer, and also checks the done pulse and output hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_requant_unit;

  localparam int SHIFT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ch_start;
  logic [4:0]  layer_idx;
  logic [9:0]  ch_idx;
  logic        relu_en;
  logic        param_rd;
  logic [4:0]  param_layer_idx;
  logic [9:0]  param_ch_idx;
  logic [31:0] bias_in;
  logic [15:0] scale_in;
  logic        param_valid;
  logic [31:0] acc_in;
  logic        acc_valid;
  logic        acc_last;
  logic        acc_ready;
  logic [7:0]  q_out;
  logic        q_valid;
  logic        q_last;
  logic        q_ready;
  logic        busy;
  logic        done;

  requant_unit dut (
    .clk(clk), .rst_n(rst_n), .ch_start(ch_start), .layer_idx(layer_idx),
    .ch_idx(ch_idx), .relu_en(relu_en), .param_rd(param_rd),
    .param_layer_idx(param_layer_idx), .param_ch_idx(param_ch_idx),
    .bias_in(bias_in), .scale_in(scale_in), .param_valid(param_valid),
    .acc_in(acc_in), .acc_valid(acc_valid), .acc_last(acc_last),
    .acc_ready(acc_ready), .q_out(q_out), .q_valid(q_valid), .q_last(q_last),
    .q_ready(q_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    bit         last;
    int         lat;
  } exp_t;

  exp_t   sb[$];
  longint acc_list[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  int     done_cnt = 0;
  bit     rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic with floor division for the shift
  function automatic logic [7:0] model(longint acc, longint bias, longint scale, bit relu);
    longint d, r;
    logic [63:0] v;
    d = longint'(1) << SHIFT;
    r = (acc + bias) * scale + d / 2;
    if (r >= 0) r = r / d;
    else        r = -((-r + d - 1) / d);
    if (relu && r < 0) r = 0;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    v = r;
    return v[7:0];
  endfunction

  function automatic longint rnd_acc();
    int x;
    if ($urandom_range(0, 3) == 0) begin
      x = int'($urandom);
      return longint'(x);
    end
    return longint'($urandom_range(0, 600)) - 300;
  endfunction

  // Output-side backpressure
  initial begin
    q_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      q_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, done pulse, stall hold
  initial begin
    exp_t       e;
    bit         exp_done = 1'b0;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_done   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        check("done", done, exp_done);
        if (exp_done) done_cnt++;
        exp_done = 1'b0;
        if (prev_stall) begin
          check("hold_valid", q_valid, 1);
          check("hold_data", {q_last, q_out}, prev_data);
        end
        if (q_valid && q_ready) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: got %0d, expected no output", q_out);
          end else begin
            e = sb.pop_front();
            check("q_out", q_out, e.q);
            check("q_last", q_last, e.last);
            if (e.lat >= 0) check("latency", cyc, e.lat);
            if (e.last) exp_done = 1'b1;
          end
        end
        prev_stall = q_valid && !q_ready;
        prev_data  = {q_last, q_out};
      end
    end
  end

  // One channel: start, parameter fetch, beat stream, wait for done.
  // abort>0 pulses reset once that many beats have been accepted.
  task automatic run_channel(input int layer, input int ch, input bit relu,
                             input longint bias, input longint scale,
                             input int pdelay, input bit chk_lat, input bit gaps,
                             input int abort);
    int     n, i, t, start_cnt;
    bit     inject;
    longint v;
    n = acc_list.size();
    @(posedge clk); #1;
    ch_start = 1'b1; layer_idx = 5'(layer); ch_idx = 10'(ch); relu_en = relu;
    @(posedge clk); #1;
    ch_start = 1'b0; layer_idx = 5'($urandom); ch_idx = 10'($urandom); relu_en = ~relu;
    @(negedge clk);
    check("fetch_param_rd", param_rd, 1);
    check("param_layer_idx", param_layer_idx, 64'(layer));
    check("param_ch_idx", param_ch_idx, 64'(ch));
    check("fetch_busy", busy, 1);
    check("fetch_acc_ready", acc_ready, 0);
    repeat (pdelay) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("wait_acc_ready", acc_ready, 0);
      check("wait_param_rd", param_rd, 0);
      check("wait_busy", busy, 1);
    end
    @(posedge clk); #1;
    v = bias;  bias_in  = v[31:0];
    v = scale; scale_in = v[15:0];
    param_valid = 1'b1;
    @(posedge clk); #1;
    param_valid = 1'b0; bias_in = $urandom; scale_in = 16'($urandom);
    i = 0;
    inject = 1'b1;
    while (i < n) begin
      if (abort > 0 && i == abort) begin
        rst_n = 1'b0;
        sb.delete();
        acc_valid = 1'b0;
        #1;
        check("rst_q_valid", q_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_acc_ready", acc_ready, 0);
        check("rst_q_last", q_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc_list.delete();
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        acc_valid = 1'b0;
        acc_in    = $urandom;
      end else begin
        acc_valid = 1'b1;
        v = acc_list[i];
        acc_in = v[31:0];
      end
      acc_last = (i == n - 1);
      if (inject) begin
        ch_start  = 1'b1;
        layer_idx = 5'(layer) ^ 5'h15;
        ch_idx    = 10'(ch) ^ 10'h2aa;
        inject    = 1'b0;
      end else begin
        ch_start = 1'b0;
      end
      @(negedge clk);
      if (acc_valid && acc_ready) begin
        sb.push_back('{model(acc_list[i], bias, scale, relu), (i == n - 1),
                       chk_lat ? cyc + 3 : -1});
        i++;
      end
      @(posedge clk); #1;
    end
    acc_valid = 1'b0; acc_last = 1'b0; ch_start = 1'b0;
    start_cnt = done_cnt;
    t = 0;
    while (done_cnt == start_cnt && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == start_cnt) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected one", t);
    end
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("sb_empty", sb.size(), 0);
    check("ctx_kept_layer", param_layer_idx, 64'(layer));
    check("ctx_kept_ch", param_ch_idx, 64'(ch));
    acc_list.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     n;
    longint b;
    rst_n = 1'b0; ch_start = 1'b0; layer_idx = '0; ch_idx = '0; relu_en = 1'b0;
    bias_in = '0; scale_in = '0; param_valid = 1'b0;
    acc_in = '0; acc_valid = 1'b0; acc_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_param_rd", param_rd, 0);
    check("rst_acc_ready", acc_ready, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q_out", q_out, 0);
    check("rst_param_layer", param_layer_idx, 0);
    check("rst_param_ch", param_ch_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_q_last", q_last, 0);

    // Rounding and latency cases, delayed parameter return
    acc_list = '{100};
    run_channel(2, 5, 1'b0, 28, 32768, 5, 1'b1, 1'b0, 0);
    acc_list = '{-1};
    run_channel(3, 9, 1'b0, 0, 32768, 0, 1'b1, 1'b0, 0);
    // Saturation both ways, with and without relu
    acc_list = '{1000000, -1000};
    run_channel(1, 1, 1'b0, 0, 65535, 1, 1'b1, 1'b0, 0);
    acc_list = '{1000000, -1000};
    run_channel(1, 2, 1'b1, 0, 65535, 2, 1'b1, 1'b0, 0);

    // Eight-beat stream under random backpressure and input gaps
    rand_ready = 1'b1;
    for (int k = 0; k < 8; k++) acc_list.push_back(rnd_acc());
    run_channel(4, 17, 1'b0, 37, 20000, 3, 1'b0, 1'b1, 0);

    // Reset with three beats in flight, then a clean channel
    rand_ready = 1'b0;
    for (int k = 0; k < 6; k++) acc_list.push_back(rnd_acc());
    run_channel(6, 33, 1'b0, 5, 40000, 0, 1'b0, 1'b0, 3);
    @(negedge clk);
    check("after_abort_busy", busy, 0);
    check("after_abort_q_valid", q_valid, 0);
    acc_list = '{200, -200, 7};
    run_channel(7, 44, 1'b0, -3, 30000, 1, 1'b1, 1'b0, 0);

    // Randomized channels
    for (int c = 0; c < 12; c++) begin
      rand_ready = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 16);
      for (int k = 0; k < n; k++) acc_list.push_back(rnd_acc());
      if ($urandom_range(0, 2) == 0) b = longint'(int'($urandom));
      else                           b = longint'($urandom_range(0, 200)) - 100;
      run_channel(int'($urandom_range(0, 31)), int'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 1)), b, longint'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 4)), 1'b0, 1'b1, 0);
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
